unified_ton_calc: RTL and testbench
===================================

UNIFIED_TON_CALC -- requirements
Module: unified_ton_calc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of interleaved buck channels (1..8).
REQ-002 SHALL have parameter VIN, default 120: input bus voltage, V.
REQ-003 SHALL have parameter L_NH, default 3300: per-channel inductance, nH.
REQ-004 SHALL have parameter FS_KHZ, default 250: switching frequency, kHz.
REQ-005 SHALL have parameter CLK_PER_TS, default 400: clk cycles per switching period.
REQ-006 SHALL have parameters TON_MAX (default 200), TON_MIN (default 4), I_REF_MAX (default 25) and V_GAP_FIXED (default 25); units are clk cycles, A and V respectively.
REQ-007 SHALL have port clk, input, 1 bit: the only clock.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-009 SHALL have port en, input, 1 bit: calculation enable.
REQ-010 SHALL have port period_start, input, 1 bit: single-cycle pulse at each Ts boundary.
REQ-011 SHALL have port gap_mode, input, 1 bit: 0 selects the measured gap voltage, 1 selects V_GAP_FIXED.
REQ-012 SHALL have port i_set, input, 16 bits unsigned: total current setpoint, A.
REQ-013 SHALL have port sample_voltage, input, 16 bits unsigned: filtered gap voltage, V.
REQ-014 SHALL have port sample_current, input, N_CH*16 bits: per-channel filtered current, signed, A, channel k in bits [16k+15:16k].
REQ-015 SHALL have port ton, output, N_CH*16 bits: per-channel inductor charging time in clk cycles, same packing as sample_current.
REQ-016 SHALL have port ton_valid, output, 1 bit: single-cycle pulse when ton updates.
REQ-017 SHALL have ports busy, overrun and vgap_fault, outputs, 1 bit each: calculation in progress; a start arrived while busy; gap voltage >= VIN.

Function
REQ-018 SHALL implement FSM IDLE -> CAPTURE -> PREP -> DIV -> STORE, with STORE returning to PREP for the next channel and going to PUBLISH after channel N_CH-1, then back to IDLE.
REQ-019 SHALL leave IDLE only when period_start=1 and en=1, and SHALL hold busy=1 in every state except IDLE.
REQ-020 In CAPTURE, SHALL register i_set, all sample_current lanes, and Vgap (sample_voltage or V_GAP_FIXED per gap_mode), so that input changes after capture do not affect the running period.
REQ-021 SHALL compute i_ref = min(i_set / N_CH with integer truncation, I_REF_MAX) and SHALL treat a negative sampled current as 0.
REQ-022 In PREP (2 cycles), SHALL form the signed 64-bit numerator NUM = CLK_PER_TS*(Vgap*(VIN-Vgap)*10^6 + 2*VIN*L_NH*FS_KHZ*(i_ref-i_d)) and the 64-bit denominator DEN = 2*VIN*(VIN-Vgap)*10^6.
REQ-023 In DIV, SHALL use a radix-2 restoring unsigned divider taking exactly 64 cycles; quotient = floor(NUM/DEN).
REQ-024 In STORE, SHALL saturate the result: NUM<=0 gives 0; quotient > TON_MAX gives TON_MAX; 0 < quotient < TON_MIN gives 0; otherwise the quotient.
REQ-025 SHALL take 67 cycles per channel; ton and ton_valid SHALL update at edge T0+2+67*N_CH, where T0 is the edge that samples period_start (270 cycles for N_CH=4).
REQ-026 SHALL update all ton lanes simultaneously in PUBLISH from a shadow buffer; ton SHALL hold its value between updates.
REQ-027 If Vgap >= VIN at capture, SHALL skip the division, publish 0 on all lanes at the same cycle as REQ-025, and set vgap_fault=1 until the next capture with Vgap < VIN.
REQ-028 If period_start=1 while busy=1, SHALL ignore the start, pulse overrun for 1 cycle, and leave the running calculation undisturbed.
REQ-029 If en falls while busy, SHALL abort to IDLE on the next edge, set every ton lane to 0, and not pulse ton_valid.
REQ-030 SHALL require at elaboration that 2+67*N_CH < CLK_PER_TS.

Reset
REQ-031 While rst=1, SHALL hold the FSM in IDLE and drive ton=0, ton_valid=0, busy=0, overrun=0 and vgap_fault=0; rst SHALL be honoured mid-calculation with no pending publish afterwards.

Verification
REQ-032 Default parameters, gap_mode=1, i_set=40, currents {10,8,12,0} -> ton lanes {41,48,34,76}, ton_valid at T0+270.
REQ-033 gap_mode=0, sample_voltage=100, i_set=200 (i_ref clamped to 25), current 0 -> raw quotient 579, ton=200 on that lane.
REQ-034 gap_mode=1, i_set=40, current 30 -> NUM<0 -> ton=0; current -5 -> treated as 0 -> ton=76.
REQ-035 gap_mode=0, sample_voltage=120 -> all lanes 0 and vgap_fault=1; a following period with sample_voltage=25 -> vgap_fault=0 and normal values.
REQ-036 Second period_start 100 cycles after the first -> overrun pulse, original result published at T0+270; en dropped at cycle 150 -> ton=0, no ton_valid; rst at cycle 200 -> all outputs 0.

Source files
------------

// File: rtl/unified_ton_calc.sv
// Per-channel inductor charging-time calculator for an interleaved buck.
// Once per switching period (period_start with en=1) it captures the gap
// voltage, the total current setpoint and every channel current, then walks
// the channels one by one through a 64-step restoring divider to produce
//   ton = floor(CLK_PER_TS*(Vg*(VIN-Vg)*1e6 + 2*VIN*L*fs*(i_ref-i_d))
//               / (2*VIN*(VIN-Vg)*1e6))
// saturated to [TON_MIN, TON_MAX] (results below TON_MIN become 0).
// All lanes are published together, 2+67*N_CH edges after the start edge.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              calculation enable; dropping it mid-run aborts and zeroes ton
//   period_start    single-cycle pulse at each switching-period boundary
//   gap_mode        0: use sample_voltage as gap voltage, 1: use V_GAP_FIXED
//   i_set           total current setpoint, A (unsigned)
//   sample_voltage  filtered gap voltage, V (unsigned)
//   sample_current  per-channel current, A (signed), lane k in [16k+15:16k]
//   ton             per-channel charging time in clk cycles, same packing
//   ton_valid       one-cycle pulse when ton updates
//   busy            calculation in progress
//   overrun         one-cycle pulse when a start arrives while busy
//   vgap_fault      captured gap voltage was >= VIN
module unified_ton_calc #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned VIN         = 120,
    parameter int unsigned L_NH        = 3300,
    parameter int unsigned FS_KHZ      = 250,
    parameter int unsigned CLK_PER_TS  = 400,
    parameter int unsigned TON_MAX     = 200,
    parameter int unsigned TON_MIN     = 4,
    parameter int unsigned I_REF_MAX   = 25,
    parameter int unsigned V_GAP_FIXED = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 period_start,
    input  logic                 gap_mode,
    input  logic [15:0]          i_set,
    input  logic [15:0]          sample_voltage,
    input  logic [N_CH*16-1:0]   sample_current,
    output logic [N_CH*16-1:0]   ton,
    output logic                 ton_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 vgap_fault
);

    localparam int unsigned LANE_W   = 16;
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DIV_W    = 64;
    localparam int unsigned DCNT_W   = 6;

    localparam logic [63:0]        SCALE = 64'd1000000;
    localparam logic signed [63:0] K_CUR = $signed(64'(2) * 64'(VIN) * 64'(L_NH) * 64'(FS_KHZ));
    localparam logic signed [63:0] CPT   = $signed(64'(CLK_PER_TS));

    // Configuration sanity: the whole calculation must fit in one period.
    if (2 + 67 * N_CH >= CLK_PER_TS) begin : g_bad_timing
        $error("unified_ton_calc: 2+67*N_CH must be less than CLK_PER_TS");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
        $error("unified_ton_calc: N_CH must be in 1..8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_PREP,
        S_DIV,
        S_STORE,
        S_PUBLISH
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0]             vgap;
    logic [15:0]             i_ref;
    logic signed [15:0]      cur_q  [N_CH];
    logic [LANE_W-1:0]       shadow [N_CH];
    logic [CH_W-1:0]         ch;
    logic                    prep_ph;
    logic [DCNT_W-1:0]       div_cnt;
    logic signed [63:0]      a_term;
    logic signed [63:0]      b_term;
    logic [DIV_W-1:0]        den;
    logic [DIV_W-1:0]        rem;
    logic [DIV_W-1:0]        quo;
    logic                    num_pos;

    logic                    abort_c;
    logic                    last_ch_c;
    logic [15:0]             cap_vgap_c;
    logic [15:0]             cap_iq_c;
    logic [15:0]             cap_iref_c;
    logic signed [15:0]      cur_sel_c;
    logic [15:0]             id_pos_c;
    logic signed [63:0]      dif_c;
    logic signed [63:0]      num_c;
    logic [DIV_W:0]          shifted_c;
    logic [DIV_W:0]          trial_c;
    logic [LANE_W-1:0]       ton_sat_c;

    // Capture-side selection and setpoint-per-channel clamp.
    always_comb begin
        cap_vgap_c = gap_mode ? 16'(V_GAP_FIXED) : sample_voltage;
        cap_iq_c   = i_set / 16'(N_CH);
        cap_iref_c = (cap_iq_c > 16'(I_REF_MAX)) ? 16'(I_REF_MAX) : cap_iq_c;
    end

    // Current-error term for the channel in flight; negative currents count as 0.
    always_comb begin
        cur_sel_c = cur_q[ch];
        id_pos_c  = cur_sel_c[15] ? 16'd0 : $unsigned(cur_sel_c);
        dif_c     = $signed(64'(i_ref)) - $signed(64'(id_pos_c));
        num_c     = CPT * (a_term + b_term);
    end

    // One restoring-division step.
    always_comb begin
        shifted_c = {rem, quo[DIV_W-1]};
        trial_c   = shifted_c - {1'b0, den};
    end

    // Output saturation of the finished quotient.
    always_comb begin
        ton_sat_c = '0;
        if (vgap_fault || !num_pos) begin
            ton_sat_c = '0;
        end else if (quo > 64'(TON_MAX)) begin
            ton_sat_c = LANE_W'(TON_MAX);
        end else if (quo < 64'(TON_MIN)) begin
            ton_sat_c = '0;
        end else begin
            ton_sat_c = quo[LANE_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; losing en anywhere outside IDLE aborts the run.
    always_comb begin
        next_state = state;
        abort_c    = 1'b0;
        last_ch_c  = (ch == CH_W'(N_CH - 1));
        case (state)
            S_IDLE:    if (period_start && en) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_PREP;
            S_PREP:    if (prep_ph) next_state = S_DIV;
            S_DIV:     if (div_cnt == DCNT_W'(DIV_W - 1)) next_state = S_STORE;
            S_STORE:   next_state = last_ch_c ? S_PUBLISH : S_PREP;
            S_PUBLISH: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (state != S_IDLE && !en) begin
            abort_c    = 1'b1;
            next_state = S_IDLE;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ton        <= '0;
            ton_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            vgap_fault <= 1'b0;
            vgap       <= '0;
            i_ref      <= '0;
            ch         <= '0;
            prep_ph    <= 1'b0;
            div_cnt    <= '0;
            a_term     <= '0;
            b_term     <= '0;
            den        <= '0;
            rem        <= '0;
            quo        <= '0;
            num_pos    <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                cur_q[k]  <= '0;
                shadow[k] <= '0;
            end
        end else begin
            ton_valid <= 1'b0;
            overrun   <= period_start && (state != S_IDLE);
            busy      <= (next_state != S_IDLE);
            if (abort_c) begin
                ton <= '0;
            end else begin
                case (state)
                    S_CAPTURE: begin
                        vgap       <= cap_vgap_c;
                        i_ref      <= cap_iref_c;
                        vgap_fault <= ({16'd0, cap_vgap_c} >= 32'(VIN));
                        for (int k = 0; k < N_CH; k++) begin
                            cur_q[k] <= $signed(sample_current[k*LANE_W +: LANE_W]);
                        end
                        ch      <= '0;
                        prep_ph <= 1'b0;
                    end
                    S_PREP: begin
                        if (!prep_ph) begin
                            a_term  <= $signed(64'(vgap) * (64'(VIN) - 64'(vgap)) * SCALE);
                            b_term  <= K_CUR * dif_c;
                            den     <= 64'(2) * 64'(VIN) * (64'(VIN) - 64'(vgap)) * SCALE;
                            prep_ph <= 1'b1;
                        end else begin
                            // Non-positive numerators divide as 0 and saturate to 0.
                            num_pos <= (num_c > 64'sd0);
                            quo     <= (num_c > 64'sd0) ? $unsigned(num_c) : '0;
                            rem     <= '0;
                            div_cnt <= '0;
                            prep_ph <= 1'b0;
                        end
                    end
                    S_DIV: begin
                        div_cnt <= div_cnt + DCNT_W'(1);
                        // With a gap fault the divisor is meaningless; just mark time.
                        if (!vgap_fault) begin
                            if (!trial_c[DIV_W]) begin
                                rem <= trial_c[DIV_W-1:0];
                                quo <= {quo[DIV_W-2:0], 1'b1};
                            end else begin
                                rem <= shifted_c[DIV_W-1:0];
                                quo <= {quo[DIV_W-2:0], 1'b0};
                            end
                        end
                    end
                    S_STORE: begin
                        shadow[ch] <= ton_sat_c;
                        ch         <= ch + CH_W'(1);
                    end
                    S_PUBLISH: begin
                        for (int k = 0; k < N_CH; k++) begin
                            ton[k*LANE_W +: LANE_W] <= shadow[k];
                        end
                        ton_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_unified_ton_calc.sv
// Directed bench for unified_ton_calc with default parameters.
// Expected ton vectors are queued when a period is started and popped when
// ton_valid is seen; latency, pulse shape, flags, abort and reset are checked.
module tb_unified_ton_calc;

    localparam int unsigned N_CH = 4;
    localparam int unsigned LAT  = 2 + 67 * N_CH;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               period_start;
    logic               gap_mode;
    logic [15:0]        i_set;
    logic [15:0]        sample_voltage;
    logic [N_CH*16-1:0] sample_current;
    logic [N_CH*16-1:0] ton;
    logic               ton_valid;
    logic               busy;
    logic               overrun;
    logic               vgap_fault;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_pub;

    unified_ton_calc dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .period_start   (period_start),
        .gap_mode       (gap_mode),
        .i_set          (i_set),
        .sample_voltage (sample_voltage),
        .sample_current (sample_current),
        .ton            (ton),
        .ton_valid      (ton_valid),
        .busy           (busy),
        .overrun        (overrun),
        .vgap_fault     (vgap_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) tick();
    endtask

    // Start a period; n counts edges after the start edge. Inputs are
    // scrambled right after the capture edge.
    task automatic start(input logic gm, input int v, input int is,
                         input logic [63:0] cur, input logic [63:0] exp, input bit push);
        gap_mode       = gm;
        sample_voltage = 16'(v);
        i_set          = 16'(is);
        sample_current = cur;
        period_start   = 1'b1;
        tick();
        period_start = 1'b0;
        n = 0;
        if (push) exp_q.push_back(exp);
        check("busy_after_start", 64'(busy), 64'd1);
        tick();
        gap_mode       = ~gm;
        sample_voltage = 16'($urandom);
        i_set          = 16'($urandom);
        sample_current = {$urandom, $urandom};
    endtask

    task automatic wait_publish(input string tag);
        int lat;
        logic [63:0] e;
        lat = -1;
        while (n < 400) begin
            tick();
            if (ton_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_queue_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check({tag, "_ton"}, ton, e);
        tick();
        check({tag, "_valid_pulse"}, 64'(ton_valid), 64'd0);
        check({tag, "_ton_hold"}, ton, e);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        last_pub = e;
    endtask

    initial begin
        bit seen;
        rst            = 1'b1;
        en             = 1'b0;
        period_start   = 1'b0;
        gap_mode       = 1'b1;
        i_set          = '0;
        sample_voltage = '0;
        sample_current = '0;
        last_pub       = '0;
        tick();
        tick();
        check("rst_ton", ton, 64'd0);
        check("rst_valid", 64'(ton_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_vgap_fault", 64'(vgap_fault), 64'd0);
        rst = 1'b0;
        en  = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Nominal fixed-gap case.
        start(1'b1, 0, 40, pack4(10, 8, 12, 0), pack4(41, 48, 34, 76), 1'b1);
        wait_publish("nominal");
        check("nominal_vgap_fault", 64'(vgap_fault), 64'd0);

        // Measured gap, i_ref clamped, quotient 579 saturates to TON_MAX.
        start(1'b0, 100, 200, pack4(0, 0, 0, 0), pack4(200, 200, 200, 200), 1'b1);
        wait_publish("clamp_max");

        // Negative numerator and negative current.
        start(1'b1, 0, 40, pack4(30, -5, 10, 8), pack4(0, 76, 41, 48), 1'b1);
        wait_publish("neg");

        // Gap fault, then recovery.
        start(1'b0, 120, 40, pack4(10, 8, 12, 0), pack4(0, 0, 0, 0), 1'b1);
        check("fault_set", 64'(vgap_fault), 64'd1);
        wait_publish("fault");
        check("fault_held", 64'(vgap_fault), 64'd1);
        start(1'b0, 25, 40, pack4(10, 8, 12, 0), pack4(41, 48, 34, 76), 1'b1);
        check("fault_clear", 64'(vgap_fault), 64'd0);
        wait_publish("recover");

        // Small quotients below TON_MIN go to 0; 6 passes.
        start(1'b0, 2, 4, pack4(1, 0, 2, 1), pack4(0, 6, 0, 0), 1'b1);
        wait_publish("ton_min");

        // Exact divisions and a negative current.
        start(1'b0, 60, 37, pack4(3, 9, -2, 1), pack4(133, 100, 149, 144), 1'b1);
        wait_publish("exact");

        // Overrun: second start 100 cycles in is ignored.
        start(1'b1, 0, 40, pack4(10, 8, 12, 0), pack4(41, 48, 34, 76), 1'b1);
        run_to(99);
        gap_mode       = 1'b0;
        sample_voltage = 16'd100;
        i_set          = 16'd200;
        period_start   = 1'b1;
        tick();
        period_start = 1'b0;
        check("overrun_pulse", 64'(overrun), 64'd1);
        check("overrun_busy", 64'(busy), 64'd1);
        tick();
        check("overrun_single", 64'(overrun), 64'd0);
        wait_publish("overrun");

        // en dropped at cycle 150: abort, ton cleared, no publish.
        start(1'b0, 100, 200, pack4(0, 0, 0, 0), '0, 1'b0);
        run_to(149);
        check("abort_ton_before", ton, last_pub);
        en = 1'b0;
        tick();
        check("abort_ton", ton, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        while (n < 300) begin
            tick();
            if (ton_valid) seen = 1'b1;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        en = 1'b1;
        tick();

        // Reset at cycle 200 of a faulted run.
        start(1'b1, 0, 40, pack4(10, 8, 12, 0), pack4(41, 48, 34, 76), 1'b1);
        wait_publish("pre_reset");
        start(1'b0, 130, 40, pack4(10, 8, 12, 0), '0, 1'b0);
        check("pre_reset_fault", 64'(vgap_fault), 64'd1);
        run_to(199);
        rst = 1'b1;
        tick();
        check("mid_rst_ton", ton, 64'd0);
        check("mid_rst_valid", 64'(ton_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_overrun", 64'(overrun), 64'd0);
        check("mid_rst_vgap_fault", 64'(vgap_fault), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        while (n < 320) begin
            tick();
            if (ton_valid || busy) seen = 1'b1;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
